// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner: row strobing, per-frame press classification,
// frame-level debounce FSM producing one key_valid pulse per accepted press.
module keypad_scan #(
    parameter int SCAN_DIV        = 100_000,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_col,
    output logic [3:0] key_row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_PRESSED,
        S_RELEASE
    } state_t;

    logic [3:0]       col_p0, col_p1;
    logic [DIV_W-1:0] div;
    logic [1:0]       row_idx;
    logic             tick, frame_end;

    logic [3:0] row_low;
    logic [2:0] row_cnt;
    logic [1:0] row_col;
    logic [3:0] row_code;
    logic       row_one, row_multi;

    logic       acc_hit, acc_multi;
    logic [3:0] acc_code;
    logic       frame_one, frame_multi, frame_none;
    logic [3:0] frame_code;

    state_t           state, state_n;
    logic [3:0]       cand, cand_n, code_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             valid_n, pressed_n;

    // Stage p0/p1: two-flop column synchronizer (idle columns read high)
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col_p0 <= 4'hF;
            col_p1 <= 4'hF;
        end else begin
            col_p0 <= key_col;
            col_p1 <= col_p0;
        end
    end

    assign tick      = (div == DIV_LAST);
    assign frame_end = tick && (row_idx == 2'd3);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div     <= '0;
            row_idx <= 2'd0;
            key_row <= 4'b1110;
        end else begin
            div <= tick ? '0 : div + 1'b1;
            if (tick) begin
                row_idx <= row_idx + 2'd1;
                key_row <= ~(4'b0001 << (row_idx + 2'd1));
            end
        end
    end

    always_comb begin
        row_low = ~col_p1;
        row_cnt = '0;
        row_col = '0;
        for (int c = 0; c < 4; c++) begin
            if (row_low[c]) begin
                row_cnt = row_cnt + 3'd1;
                row_col = 2'(c);
            end
        end
    end

    assign row_one   = (row_cnt == 3'd1);
    assign row_multi = (row_cnt > 3'd1);
    assign row_code  = {row_idx, row_col};

    // Frame result folds in the row being sampled on this tick, so row 3 counts too.
    assign frame_multi = acc_multi | row_multi | (acc_hit & row_one);
    assign frame_one   = !frame_multi && (acc_hit || row_one);
    assign frame_none  = !frame_multi && !frame_one;
    assign frame_code  = acc_hit ? acc_code : row_code;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc_hit   <= 1'b0;
            acc_multi <= 1'b0;
            acc_code  <= 4'd0;
        end else if (tick) begin
            if (row_idx == 2'd3) begin
                acc_hit   <= 1'b0;
                acc_multi <= 1'b0;
                acc_code  <= 4'd0;
            end else begin
                acc_multi <= frame_multi;
                acc_hit   <= acc_hit | row_one;
                if (row_one && !acc_hit) begin
                    acc_code <= row_code;
                end
            end
        end
    end

    always_comb begin
        state_n   = state;
        cand_n    = cand;
        cnt_n     = cnt;
        code_n    = key_code;
        valid_n   = 1'b0;
        pressed_n = key_pressed;
        if (frame_end) begin
            case (state)
                S_IDLE: begin
                    if (frame_one) begin
                        cand_n  = frame_code;
                        cnt_n   = CNT_ONE;
                        state_n = S_DEBOUNCE;
                    end
                end
                S_DEBOUNCE: begin
                    if (frame_one && frame_code == cand) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == CNT_DONE) begin
                            code_n    = cand;
                            valid_n   = 1'b1;
                            pressed_n = 1'b1;
                            state_n   = S_PRESSED;
                        end
                    end else if (frame_one) begin
                        cand_n = frame_code;
                        cnt_n  = CNT_ONE;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
                S_PRESSED: begin
                    if (!(frame_one && frame_code == key_code)) begin
                        pressed_n = 1'b0;
                        cnt_n     = frame_none ? CNT_ONE : '0;
                        state_n   = S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (frame_none) begin
                        cnt_n = cnt + 1'b1;
                        if (cnt_n == CNT_DONE) begin
                            state_n = S_IDLE;
                        end
                    end else begin
                        cnt_n = '0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= S_IDLE;
            cand        <= 4'd0;
            cnt         <= '0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_pressed <= 1'b0;
        end else begin
            state       <= state_n;
            cand        <= cand_n;
            cnt         <= cnt_n;
            key_code    <= code_n;
            key_valid   <= valid_n;
            key_pressed <= pressed_n;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: simulated key matrix, frame-level reference model, scenario tasks.
module tb_keypad_scan;
    localparam int SCAN_DIV = 4;
    localparam int DF       = 3;
    localparam logic [63:0] ROWS_EXP = 64'h7777_BBBB_DDDD_EEEE;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic [3:0] key_col;
    logic [3:0] key_row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    logic [15:0] kmask = '0;
    int errors = 0;
    int checks = 0;

    // reference model state (frame level)
    bit         m_held, m_releasing;
    int         m_quiet, m_run, m_run_code;
    logic [3:0] m_code;
    logic [15:0] e_valid, e_pressed;
    logic [3:0]  e_code;

    logic [15:0] obs_valid, obs_pressed;
    logic [63:0] obs_rows;
    logic [3:0]  obs_code;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DF)) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .key_col    (key_col),
        .key_row    (key_row),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_pressed(key_pressed)
    );

    always #5 sys_clk = ~sys_clk;

    // ideal matrix: a pressed key pulls its column low while its row is driven low
    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!key_row[r] && kmask[r*4+c]) key_col[c] = 1'b0;
    end

    function automatic void model_reset();
        m_held = 0; m_releasing = 0; m_quiet = 0; m_run = 0; m_run_code = 0;
        m_code = 4'd0; e_valid = '0; e_pressed = '0; e_code = 4'd0;
    endfunction

    // A frame reads as a single key only when exactly one key is down anywhere.
    function automatic void model_frame(input logic [15:0] mask);
        int hits = $countones(mask);
        int code = -1;
        bit one, none;
        for (int k = 0; k < 16; k++) if (mask[k]) code = k;
        one  = (hits == 1);
        none = (hits == 0);
        e_valid = '0;
        if (m_held) begin
            if (!(one && code == int'(m_code))) begin
                m_held = 0; m_releasing = 1; m_quiet = none ? 1 : 0;
            end
        end else if (m_releasing) begin
            if (none) begin
                m_quiet++;
                if (m_quiet >= DF) begin m_releasing = 0; m_run = 0; end
            end else m_quiet = 0;
        end else if (one) begin
            m_run = (m_run > 0 && code == m_run_code) ? m_run + 1 : 1;
            m_run_code = code;
            if (m_run >= DF) begin
                m_held = 1; m_code = 4'(code); e_valid = 16'h0001; m_run = 0;
            end
        end else m_run = 0;
        e_pressed = m_held ? 16'hFFFF : 16'h0000;
        e_code    = m_code;
    endfunction

    // Drives one 16-cycle frame starting at phase 0 and records what the DUT shows.
    task automatic run_frame(input logic [15:0] mask);
        kmask = mask;
        for (int i = 0; i < 16; i++) begin
            obs_valid[i]       = key_valid;
            obs_pressed[i]     = key_pressed;
            obs_rows[i*4 +: 4] = key_row;
            if (i == 15) obs_code = key_code;
            @(negedge sys_clk);
        end
    endtask

    task automatic release_reset();
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [15:0] seq[$];
        sys_rst_n = 1'b0;
        kmask = '0;
        repeat (3) @(negedge sys_clk);
        checks++;
        if ({key_row, key_code, key_valid, key_pressed} !== {4'b1110, 4'd0, 1'b0, 1'b0})
            begin errors++; $display("FAIL reset_state: row=%b code=%0d valid=%b pressed=%b, required row=1110 code=0 valid=0 pressed=0", key_row, key_code, key_valid, key_pressed); end
        release_reset();
        seq = '{16'h0, 16'h0, 16'h0, 16'h0};
        foreach (seq[k]) begin
            run_frame(seq[k]);
            checks++;
            if ({obs_valid, obs_pressed, obs_code} !== {e_valid, e_pressed, e_code})
                begin errors++; $display("FAIL idle_scan f%0d: valid=%h pressed=%h code=%0d, required valid=%h pressed=%h code=%0d", k, obs_valid, obs_pressed, obs_code, e_valid, e_pressed, e_code); end
            checks++;
            if (obs_rows !== ROWS_EXP)
                begin errors++; $display("FAIL idle_rows f%0d: rows=%h, required %h", k, obs_rows, ROWS_EXP); end
            model_frame(seq[k]);
        end
    endtask

    task automatic test_hold();
        logic [15:0] seq[$];
        int pulses = 0;
        for (int k = 0; k < 10; k++) seq.push_back(16'h0200);
        for (int k = 0; k < 4; k++) seq.push_back(16'h0000);
        foreach (seq[k]) begin
            run_frame(seq[k]);
            pulses += $countones(obs_valid);
            checks++;
            if ({obs_valid, obs_pressed, obs_code} !== {e_valid, e_pressed, e_code})
                begin errors++; $display("FAIL hold f%0d: valid=%h pressed=%h code=%0d, required valid=%h pressed=%h code=%0d", k, obs_valid, obs_pressed, obs_code, e_valid, e_pressed, e_code); end
            checks++;
            if (obs_rows !== ROWS_EXP)
                begin errors++; $display("FAIL hold_rows f%0d: rows=%h, required %h", k, obs_rows, ROWS_EXP); end
            model_frame(seq[k]);
        end
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL hold_pulse_count: got %0d, required 1", pulses); end
        checks++;
        if (key_code !== 4'd9) begin errors++; $display("FAIL hold_code_kept: got %0d, required 9", key_code); end
    endtask

    task automatic test_bounce();
        logic [15:0] seq[$];
        for (int k = 0; k < 5; k++) begin seq.push_back(16'h0040); seq.push_back(16'h0000); end
        for (int k = 0; k < 4; k++) seq.push_back(16'h0040);
        for (int k = 0; k < 4; k++) seq.push_back(16'h0000);
        foreach (seq[k]) begin
            run_frame(seq[k]);
            checks++;
            if ({obs_valid, obs_pressed, obs_code} !== {e_valid, e_pressed, e_code})
                begin errors++; $display("FAIL bounce f%0d: valid=%h pressed=%h code=%0d, required valid=%h pressed=%h code=%0d", k, obs_valid, obs_pressed, obs_code, e_valid, e_pressed, e_code); end
            model_frame(seq[k]);
        end
    endtask

    task automatic test_multi();
        logic [15:0] seq[$];
        for (int k = 0; k < 6; k++) seq.push_back(16'h0021);
        for (int k = 0; k < 4; k++) seq.push_back(16'h0001);
        for (int k = 0; k < 4; k++) seq.push_back(16'h0000);
        foreach (seq[k]) begin
            run_frame(seq[k]);
            checks++;
            if ({obs_valid, obs_pressed, obs_code} !== {e_valid, e_pressed, e_code})
                begin errors++; $display("FAIL multi f%0d: valid=%h pressed=%h code=%0d, required valid=%h pressed=%h code=%0d", k, obs_valid, obs_pressed, obs_code, e_valid, e_pressed, e_code); end
            model_frame(seq[k]);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] seq[$];
        int pulses = 0;
        int plan[6][2] = '{'{4, 1}, '{2, 0}, '{3, 1}, '{3, 0}, '{4, 1}, '{4, 0}};
        for (int p = 0; p < 6; p++)
            for (int k = 0; k < plan[p][0]; k++) seq.push_back(plan[p][1] != 0 ? 16'h8000 : 16'h0000);
        foreach (seq[k]) begin
            run_frame(seq[k]);
            pulses += $countones(obs_valid);
            checks++;
            if ({obs_valid, obs_pressed, obs_code} !== {e_valid, e_pressed, e_code})
                begin errors++; $display("FAIL repress f%0d: valid=%h pressed=%h code=%0d, required valid=%h pressed=%h code=%0d", k, obs_valid, obs_pressed, obs_code, e_valid, e_pressed, e_code); end
            model_frame(seq[k]);
        end
        checks++;
        if (pulses != 2) begin errors++; $display("FAIL repress_pulse_count: got %0d, required 2", pulses); end
    endtask

    task automatic test_reset_midpress();
        logic [15:0] seq[$];
        for (int k = 0; k < 4; k++) begin
            run_frame(16'h0008);
            model_frame(16'h0008);
        end
        checks++;
        if ({key_pressed, key_code} !== {1'b1, 4'd3})
            begin errors++; $display("FAIL midpress_pre: pressed=%b code=%0d, required pressed=1 code=3", key_pressed, key_code); end
        repeat (7) @(negedge sys_clk);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({key_row, key_code, key_valid, key_pressed} !== {4'b1110, 4'd0, 1'b0, 1'b0})
            begin errors++; $display("FAIL midpress_reset: row=%b code=%0d valid=%b pressed=%b, required row=1110 code=0 valid=0 pressed=0", key_row, key_code, key_valid, key_pressed); end
        @(negedge sys_clk);
        release_reset();
        for (int k = 0; k < 5; k++) seq.push_back(16'h0008);
        for (int k = 0; k < 4; k++) seq.push_back(16'h0000);
        foreach (seq[k]) begin
            run_frame(seq[k]);
            checks++;
            if ({obs_valid, obs_pressed, obs_code} !== {e_valid, e_pressed, e_code})
                begin errors++; $display("FAIL post_reset f%0d: valid=%h pressed=%h code=%0d, required valid=%h pressed=%h code=%0d", k, obs_valid, obs_pressed, obs_code, e_valid, e_pressed, e_code); end
            checks++;
            if (obs_rows !== ROWS_EXP)
                begin errors++; $display("FAIL post_reset_rows f%0d: rows=%h, required %h", k, obs_rows, ROWS_EXP); end
            model_frame(seq[k]);
        end
    endtask

    task automatic test_random();
        logic [15:0] seq[$];
        logic [15:0] m;
        int last = 0;
        for (int seg = 0; seg < 24; seg++) begin
            int mode = $urandom_range(0, 9);
            int len  = $urandom_range(1, 5);
            if (mode < 2) m = 16'h0;
            else if (mode == 2) begin
                m = 16'h0;
                while ($countones(m) < 2) m[$urandom_range(0, 15)] = 1'b1;
            end else begin
                if (mode > 5) last = $urandom_range(0, 15);
                m = 16'h0;
                m[last] = 1'b1;
            end
            for (int k = 0; k < len; k++) seq.push_back(m);
        end
        for (int k = 0; k < 4; k++) seq.push_back(16'h0000);
        foreach (seq[k]) begin
            run_frame(seq[k]);
            checks++;
            if ({obs_valid, obs_pressed, obs_code} !== {e_valid, e_pressed, e_code})
                begin errors++; $display("FAIL random f%0d mask=%h: valid=%h pressed=%h code=%0d, required valid=%h pressed=%h code=%0d", k, seq[k], obs_valid, obs_pressed, obs_code, e_valid, e_pressed, e_code); end
            checks++;
            if (obs_rows !== ROWS_EXP)
                begin errors++; $display("FAIL random_rows f%0d: rows=%h, required %h", k, obs_rows, ROWS_EXP); end
            model_frame(seq[k]);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hold();
        test_bounce();
        test_multi();
        test_back_to_back();
        test_reset_midpress();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- 4x4 matrix keypad scanner: the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one active-low row at a time, reads the active-low columns, debounces and produces one single-cycle key event per press.
- Sits between the board keypad pins and the vending-machine control FSM, which receives item or coin selections as 4-bit key codes.

Parameters:
SCAN_DIV, 100_000, sys_clk cycles each row is driven before it is sampled and the scan advances (min 4)
DEBOUNCE_FRAMES, 4, consecutive identical full-frame results needed to accept a press or a release (min 2)

Ports:
sys_clk  input  1  system clock
sys_rst_n  input  1  asynchronous active-low reset
key_col  input  4  keypad columns, active low (pulled up on board); bit i = column i
key_row  output  4  keypad row drive, active low, exactly one bit low at all times
key_code  output  4  code of last accepted key = row*4 + col
key_valid  output  1  one-cycle pulse when a debounced press is accepted
key_pressed  output  1  high while the accepted key is held (PRESSED state)

Behaviour:
- Reset (async, sys_rst_n low): row_idx=0, key_row=4'b1110, key_code=0, key_valid=0, key_pressed=0, divider=0, synchronizer=4'b1111, FSM=IDLE, all counters and frame accumulators cleared.
- key_col passes through a 2-flop synchronizer before use.
- Divider counts 0..SCAN_DIV-1. The terminal count is the tick.
- On each tick:
  - Sample the synchronized columns for the current row_idx.
  - Advance row_idx 0→1→2→3→0.
  - key_row = ~(1<<row_idx), registered.
- Frame accumulation over rows 0..3:
  - Track hit count and the code of the hit.
  - One low column in a row adds 1 hit with code row*4+col.
  - More than one low column in a row marks MULTI.
  - Hits summed across rows greater than 1 mark MULTI.
- At the row-3 tick the frame result is NONE (0 hits), ONE(code), or MULTI. The accumulator then clears for the next frame.
- FSM evaluates only on frame-end ticks:
  - IDLE:
    - ONE(c): cand=c, cnt=1, go DEBOUNCE.
    - NONE or MULTI: stay.
  - DEBOUNCE:
    - ONE(cand): cnt++. When cnt reaches DEBOUNCE_FRAMES: key_code<=cand, key_valid=1 for exactly the next cycle, key_pressed<=1, go PRESSED.
    - ONE(other): cand=other, cnt=1.
    - NONE or MULTI: go IDLE.
  - PRESSED:
    - ONE(key_code): stay.
    - NONE: key_pressed<=0, cnt=1, go RELEASE.
    - MULTI or ONE(other): key_pressed<=0, cnt=0, go RELEASE.
  - RELEASE:
    - NONE: cnt++. When cnt reaches DEBOUNCE_FRAMES, go IDLE.
    - Anything else: cnt=0, stay.
- Latency: key_valid rises one sys_clk after the frame-end tick of the DEBOUNCE_FRAMES-th consecutive matching frame.
- key_code holds its value until the next accepted press. Nothing is emitted on release.
- Held key: exactly one key_valid pulse per press. There is no auto-repeat.
- The debounce counter width must hold DEBOUNCE_FRAMES. The divider width is clog2(SCAN_DIV).
- Reset mid-scan or mid-press aborts everything. After reset, a still-held key is treated as a new press and is re-debounced from IDLE.

Test Plan:
All tests use SCAN_DIV=4, DEBOUNCE_FRAMES=3. One frame = 16 cycles.
1. Reset asserted, then released with no key → key_row=4'b1110, then 1101,1011,0111,1110 every 4 cycles; key_valid never 1; key_pressed=0; key_code=0.
2. Hold key row2/col1 (key_col bit1 low whenever key_row=1011) for 10 frames → exactly one key_valid pulse, one cycle after the 3rd complete matching frame end; key_code=9; key_pressed=1 until release.
3. Bounce: key 6 pressed 1 frame, released 1 frame, repeated 5 times → no key_valid; FSM returns to IDLE.
4. Keys 0 and 5 held together for 6 frames → no key_valid. Then release key 5 only → key_valid with key_code=0 after 3 frames.
5. Press key 15 and accept it. Release for 2 frames, re-press for 3 frames → no second pulse. Release for 3 frames, then press for 3 frames → second pulse, key_code=15.
6. Key 3 accepted (key_pressed=1), then sys_rst_n pulsed low mid-frame with the key still held → outputs and key_row=4'b1110 go to reset values immediately; a new key_valid with key_code=3 occurs 3 frames after reset release.
